// File: rtl/mem_pkg.sv
// Types and defaults shared by the backing memory and cache-side code.
package mem_pkg;
    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;

    localparam int DEFAULT_LATENCY   = 4;
    localparam int DEFAULT_ADDR_BITS = 11;
endpackage

// File: rtl/mem_array.sv
// Word storage: one synchronous write port and one asynchronous read port, cleared on reset.
// Writes land at the clock edge; read data follows i_rd_idx combinationally.
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 i_wr_en,
    input  logic [ADDR_BITS-1:0] i_wr_idx,
    input  word_t                i_wr_dat,
    input  logic [ADDR_BITS-1:0] i_rd_idx,
    output word_t                o_rd_dat
);
    localparam int DEPTH = 1 << ADDR_BITS;

    word_t r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_dat;
        end
    end

    assign o_rd_dat = r_mem[i_rd_idx];
endmodule

// File: rtl/backing_memory.sv
// Latency-modelled backing memory: read data is valid once the word address is held LATENCY edges.
// Optional BACKING_MEMORY_BOUNDS_CHECK_EN drops out-of-range writes, zeroes such reads and flags mem_err.
module backing_memory
    import mem_pkg::*;
#(
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
    parameter int LATENCY   = DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [31:0] mem_addr,
    input  logic        mem_write_en,
    input  byte_t       mem_data_in  [0:3],
    output byte_t       mem_data_out [0:3],
    output logic        mem_valid,
    output logic        mem_wr_done,
    output logic        mem_err
);
    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [0:0] {ST_WAIT, ST_VALID} state_t;

    state_t               r_state;
    logic [3:0]           r_cnt;
    logic [ADDR_BITS-1:0] r_last_addr;
    logic                 r_valid;
    logic                 r_wr_done;
    logic                 r_err;
    byte_t                r_data [0:3];

    logic [ADDR_BITS-1:0] w_idx;
    logic                 w_oob;
    logic                 w_wr;
    logic                 w_restart;
    logic [3:0]           w_cnt_nxt;
    word_t                w_wr_word;
    word_t                w_rd_word;
    logic                 w_unused;

    assign w_idx     = mem_addr[ADDR_BITS+1:2];
    assign w_wr_word = {mem_data_in[3], mem_data_in[2], mem_data_in[1], mem_data_in[0]};
    assign w_unused  = &{1'b0, mem_addr[1:0], mem_addr[31:ADDR_BITS+2]};

`ifdef BACKING_MEMORY_BOUNDS_CHECK_EN
    assign w_oob = |mem_addr[31:ADDR_BITS+2];
`else
    assign w_oob = 1'b0;
`endif

    assign w_wr = mem_write_en & ~w_oob;

    // A write restarts the count so a read of the just-written word never shows stale data.
    assign w_restart = (w_idx != r_last_addr) || mem_write_en;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_restart) begin
            w_cnt_nxt = 4'd0;
        end else if (r_cnt != LAT) begin
            w_cnt_nxt = r_cnt + 4'd1;
        end
    end

    mem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_mem_array (
        .clk      (clk),
        .rst_b    (rst_b),
        .i_wr_en  (w_wr),
        .i_wr_idx (w_idx),
        .i_wr_dat (w_wr_word),
        .i_rd_idx (w_idx),
        .o_rd_dat (w_rd_word)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state     <= ST_WAIT;
            r_cnt       <= 4'd0;
            r_last_addr <= '0;
            r_valid     <= 1'b0;
            r_wr_done   <= 1'b0;
            r_err       <= 1'b0;
            for (int b = 0; b < 4; b++) begin
                r_data[b] <= 8'h00;
            end
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_last_addr <= w_idx;
            r_wr_done   <= w_wr;
            r_err       <= w_oob;
            case (r_state)
                ST_WAIT: begin
                    if (w_cnt_nxt == LAT) begin
                        r_state <= ST_VALID;
                        r_valid <= 1'b1;
                        for (int b = 0; b < 4; b++) begin
                            r_data[b] <= w_oob ? 8'h00 : w_rd_word[8*b +: 8];
                        end
                    end
                end
                ST_VALID: begin
                    if (w_cnt_nxt != LAT) begin
                        r_state <= ST_WAIT;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_WAIT;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mem_data_out = r_data;
    assign mem_valid    = r_valid;
    assign mem_wr_done  = r_wr_done;
`ifdef BACKING_MEMORY_BOUNDS_CHECK_EN
    assign mem_err      = r_err;
`else
    assign mem_err      = 1'b0;
`endif
endmodule
